// File: rtl/vram_responder_if.sv
// Wishbone pipelined bus bundle shared by the display fetch port and the CPU port.
// The slave view is the one the video memory responder implements.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;

    modport slave (
        input  cyc, stb, adr, we, sel, dat_i,
        output ack, stall, dat_o
    );

    modport master (
        output cyc, stb, adr, we, sel, dat_i,
        input  ack, stall, dat_o
    );
endinterface

// File: rtl/vram_responder.sv
// Video frame/text memory: one single-port 32-bit RAM shared by the display fetch bus
// and the CPU bus, display-first arbitration with a bounded CPU wait.
module vram_responder #(
    parameter int AWIDTH       = 15,
    parameter int CPU_MAX_WAIT = 4
) (
    input logic  clk_i,
    input logic  rst_i,
    if_wb.slave  vidbus,
    if_wb.slave  cpubus
);

    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    logic              vid_req;
    logic              cpu_req;
    logic              vid_gnt;
    logic              cpu_gnt;
    logic [3:0]        wait_cnt;
    logic [AWIDTH-1:0] idx;
    logic              ram_rd;

    logic [31:0]       mem [0:(1<<AWIDTH)-1];
    logic [31:0]       rd_data_p1;
    logic              vid_vld_p1;
    logic              vid_rd_p1;
    logic              cpu_vld_p1;
    logic              cpu_rd_p1;
    logic              vid_ack;
    logic              cpu_ack;
    logic              unused_bits;

    assign vid_req = vidbus.cyc & vidbus.stb;
    assign cpu_req = cpubus.cyc & cpubus.stb;

    always_comb begin
        vid_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (vid_req && (!cpu_req || wait_cnt < MAX_WAIT)) begin
            vid_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end
    end

    assign vidbus.stall = vid_req & ~vid_gnt;
    assign cpubus.stall = cpu_req & ~cpu_gnt;

    // Counts consecutive stalled CPU request cycles; saturates so the forced grant holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (cpu_gnt || !cpubus.cyc) begin
            wait_cnt <= '0;
        end else if (cpu_req && wait_cnt < MAX_WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign idx    = cpu_gnt ? cpubus.adr[AWIDTH+1:2] : vidbus.adr[AWIDTH+1:2];
    assign ram_rd = (cpu_gnt & ~cpubus.we) | (vid_gnt & ~vidbus.we);

    // Stage p0 -> p1: RAM access; display-port writes are acked but never stored.
    always_ff @(posedge clk_i) begin
        if (cpu_gnt && cpubus.we) begin
            for (int k = 0; k < 4; k++) begin
                if (cpubus.sel[k]) begin
                    mem[idx][8*k +: 8] <= cpubus.dat_i[8*k +: 8];
                end
            end
        end else if (ram_rd) begin
            rd_data_p1 <= mem[idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vid_vld_p1 <= 1'b0;
            vid_rd_p1  <= 1'b0;
            cpu_vld_p1 <= 1'b0;
            cpu_rd_p1  <= 1'b0;
        end else begin
            vid_vld_p1 <= vid_gnt;
            vid_rd_p1  <= vid_gnt & ~vidbus.we;
            cpu_vld_p1 <= cpu_gnt;
            cpu_rd_p1  <= cpu_gnt & ~cpubus.we;
        end
    end

    // Stage p1 output: a master that dropped cyc abandons its pending ack.
    assign vid_ack = vid_vld_p1 & vidbus.cyc;
    assign cpu_ack = cpu_vld_p1 & cpubus.cyc;

    assign vidbus.ack   = vid_ack;
    assign cpubus.ack   = cpu_ack;
    assign vidbus.dat_o = (vid_ack && vid_rd_p1) ? rd_data_p1 : 32'h0;
    assign cpubus.dat_o = (cpu_ack && cpu_rd_p1) ? rd_data_p1 : 32'h0;

    assign unused_bits = ^{vidbus.adr, vidbus.sel, vidbus.dat_i, cpubus.adr};

endmodule
